uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 2, giving the number of requesters (legal 2..4).
REQ-002 The block SHALL have parameter CLK_DIV, default 104, giving clock cycles per serial bit (legal 4..65535).
REQ-003 The block SHALL have parameter LOCK_TIMEOUT, default 1024, giving idle cycles before a packet lock is dropped (0 = never).
REQ-004 Port clk, input, 1, is the single clock; all state changes on its rising edge.
REQ-005 Port resetn, input, 1, is the asynchronous, active-low reset.
REQ-006 Port req_valid, input, NREQ, carries per-requester byte-valid flags.
REQ-007 Port req_data, input, 8*NREQ, carries the byte for requester i in bits [8i+7:8i].
REQ-008 Port req_last, input, NREQ, marks the final byte of a packet from requester i.
REQ-009 Port req_ready, output, NREQ, is a one-hot accept strobe; byte i is transferred when req_valid[i] and req_ready[i] are both high.
REQ-010 Port ser_tx, output, 1, is the UART line: 8N1, LSB first, idle high.
REQ-011 Port busy, output, 1, is high while a frame is shifting or a packet lock is held.
REQ-012 Port grant_id, output, 2, gives the index of the current or last owner.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP; the lock flag and owner index are held separately.
REQ-014 IDLE, unlocked: the arbiter SHALL pick among valid requesters and assert req_ready for the winner in the same cycle; ser_tx SHALL go low on the next cycle (START).
REQ-015 START, each of the 8 DATA bits, and STOP SHALL each last exactly CLK_DIV cycles; a frame lasts 10*CLK_DIV cycles.
REQ-016 An accepted byte with req_last=0 SHALL set the lock; while locked, only the owner SHALL be granted.
REQ-017 While locked, in the final STOP cycle with owner valid high, the next byte SHALL be accepted, so frames run back-to-back with no idle gap.
REQ-018 An accepted byte with req_last=1 SHALL clear the lock at the end of its STOP bit.
REQ-019 If locked and the owner's valid stays low for LOCK_TIMEOUT consecutive IDLE cycles, the lock SHALL clear (LOCK_TIMEOUT=0: never).
REQ-020 req_ready SHALL never be asserted outside IDLE or the final STOP cycle, and SHALL never be asserted for more than one requester.
REQ-021 Data bytes SHALL be latched on acceptance; later changes on req_data SHALL not affect the frame in flight.
REQ-022 Arbitration SHALL occur only when unlocked; a requester that deasserts valid before acceptance SHALL simply lose that arbitration.

Reset
REQ-023 With resetn low: ser_tx=1, req_ready=0, busy=0, grant_id=0, state IDLE, lock cleared, bit and baud counters 0, round-robin pointer 0.
REQ-024 Reset mid-frame SHALL abort the frame immediately, with ser_tx high asynchronously; no byte SHALL be re-sent after release.

Configuration
REQ-025 With macro UART_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority, with the lowest index winning.
REQ-026 Without UART_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin: the search starts at last owner+1, modulo NREQ, and the pointer updates only on a granted packet start.

Verification
REQ-027 Single byte: NREQ=2, CLK_DIV=8, req0 sends 0x55 with last=1 -> ready pulse 1 cycle; ser_tx low 8 cycles, then 1,0,1,0,1,0,1,0, then high; busy drops after 80 cycles.
REQ-028 Packet lock: req0 sends "AB" (A last=0, B last=1) while req1 holds 0x5A valid -> line carries 0x41, 0x42, 0x5A in that order; 0x42 starts exactly 80 cycles after 0x41 start.
REQ-029 Round robin (macro off): both requesters always valid with single-byte packets -> grant_id alternates 0,1,0,1; with macro on -> grant_id stays 0.
REQ-030 Timeout: LOCK_TIMEOUT=16, req0 sends last=0 then drops valid -> lock clears after 16 idle cycles, and req1's pending byte is granted on the next cycle.
REQ-031 Reset abort: resetn pulsed low in bit 3 of a frame -> ser_tx=1 at once, all outputs at reset values, line idle afterward.
REQ-032 Data hold: req_data changed from 0x00 to 0xFF one cycle after acceptance -> transmitted byte is still 0x00.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: arbitrates NREQ byte streams onto one 8N1 UART line with
// per-packet locking and an idle-lock timeout.
// Build option: define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins);
// otherwise arbitration is round-robin starting after the last owner.
module uart_tx_arbiter #(
  parameter int unsigned NREQ         = 2,
  parameter int unsigned CLK_DIV      = 104,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              ser_tx,
  output logic              busy,
  output logic [1:0]        grant_id
);

  localparam int unsigned BW = $clog2(CLK_DIV);
  localparam int unsigned TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          last_q, last_d;
  logic [1:0]    owner_q, owner_d;
  logic          lock_q, lock_d;
  logic [TW-1:0] to_q, to_d;
  logic          tx_q, tx_d;

  // Requester vectors padded to the full 4-requester index space
  logic [3:0]  valid_ext;
  logic [3:0]  last_ext;
  logic [31:0] data_ext;
  assign valid_ext = 4'(req_valid);
  assign last_ext  = 4'(req_last);
  assign data_ext  = 32'(req_data);

  logic       arb_found;
  logic [1:0] arb_idx;
  logic       baud_end;
  logic       final_stop;
  logic       grant_en;
  logic [1:0] grant_idx;

  assign baud_end   = (baud_q == BAUD_MAX);
  assign final_stop = (state_q == STOP) && baud_end;

`ifdef UART_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest valid index wins
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (valid_ext[2'(k)]) begin
        arb_found = 1'b1;
        arb_idx   = 2'(k);
      end
    end
  end
`else
  logic [1:0] cand;

  // Round-robin: search from last owner + 1; descending loop so nearest wins
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      cand = 2'((32'(owner_q) + 32'(k)) % NREQ);
      if (valid_ext[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end
`endif

  // Grant decision: owner-only while locked, open arbitration in unlocked IDLE
  always_comb begin
    grant_en  = 1'b0;
    grant_idx = owner_q;
    if (lock_q) begin
      if (valid_ext[owner_q] && ((state_q == IDLE) || (final_stop && !last_q))) begin
        grant_en = 1'b1;
      end
    end else if (state_q == IDLE) begin
      grant_en  = arb_found;
      grant_idx = arb_idx;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: an accepted byte always (re)starts a frame
  always_comb begin
    state_d = state_q;
    if (grant_en) begin
      state_d = START;
    end else begin
      case (state_q)
        START:   if (baud_end) state_d = DATA;
        DATA:    if (baud_end && (bit_q == 3'd7)) state_d = STOP;
        STOP:    if (baud_end) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath next values: byte latch, baud/bit counters, lock and timeout
  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    owner_d = owner_q;
    lock_d  = lock_q;
    to_d    = to_q;
    tx_d    = tx_q;
    if (grant_en) begin
      baud_d  = '0;
      bit_d   = 3'd0;
      shreg_d = data_ext[{grant_idx, 3'b000} +: 8];
      last_d  = last_ext[grant_idx];
      owner_d = grant_idx;
      lock_d  = lock_q | ~last_ext[grant_idx];
      to_d    = '0;
      tx_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_d   = 1'b1;
          baud_d = '0;
          if (lock_q && (LOCK_TIMEOUT != 0)) begin
            if (to_q == TO_MAX) begin
              lock_d = 1'b0;
              to_d   = '0;
            end else begin
              to_d = to_q + TW'(1);
            end
          end
        end
        START: begin
          if (baud_end) begin
            baud_d = '0;
            tx_d   = shreg_q[0];
          end else begin
            baud_d = baud_q + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_d  = '0;
            shreg_d = {1'b0, shreg_q[7:1]};
            if (bit_q == 3'd7) begin
              tx_d = 1'b1;
            end else begin
              bit_d = bit_q + 3'd1;
              tx_d  = shreg_q[1];
            end
          end else begin
            baud_d = baud_q + BW'(1);
          end
        end
        default: begin
          if (baud_end) begin
            baud_d = '0;
            tx_d   = 1'b1;
            if (last_q) lock_d = 1'b0;
          end else begin
            baud_d = baud_q + BW'(1);
          end
        end
      endcase
    end
  end

  // Datapath registers; line forced idle-high asynchronously in reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'd0;
      last_q  <= 1'b0;
      owner_q <= 2'd0;
      lock_q  <= 1'b0;
      to_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      lock_q  <= lock_d;
      to_q    <= to_d;
      tx_q    <= tx_d;
    end
  end

  // Outputs: same-cycle one-hot accept strobe, status from registers
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      req_ready[i] = grant_en && (grant_idx == 2'(i));
    end
    ser_tx   = tx_q;
    busy     = (state_q != IDLE) || lock_q;
    grant_id = owner_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected bytes are queued at acceptance
// and checked by a serial-line receiver; control timing is checked inline.
module tb_uart_tx_arbiter;

  localparam int CLK_DIV = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        ser_tx;
  logic        busy;
  logic [1:0]  grant_id;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_tx_arbiter #(.NREQ(2), .CLK_DIV(CLK_DIV), .LOCK_TIMEOUT(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .ser_tx    (ser_tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int max, output int n);
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(input int max, output int n);
    #1;
    n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
  endtask

  // Serial receiver: samples mid-bit, drops frames cut by reset
  initial begin : monitor
    logic [7:0] rx;
    logic       stopb;
    logic       ab;
    int         t0;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && ser_tx === 1'b0) begin
        t0 = cyc;
        ab = 1'b0;
        rx = 8'd0;
        repeat (CLK_DIV / 2) begin
          @(negedge clk);
          if (resetn !== 1'b1) ab = 1'b1;
        end
        for (int b = 0; b < 8; b++) begin
          repeat (CLK_DIV) begin
            @(negedge clk);
            if (resetn !== 1'b1) ab = 1'b1;
          end
          rx[b] = ser_tx;
        end
        repeat (CLK_DIV) begin
          @(negedge clk);
          if (resetn !== 1'b1) ab = 1'b1;
        end
        stopb = ser_tx;
        if (!ab) begin
          start_q.push_back(t0);
          chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) chk("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
          chk("stop_bit", 32'(stopb), 32'd1);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    int gap;
    int prev;
    int e;
    logic [1:0] oh;

    resetn = 1'b0; req_valid = 2'b00; req_data = 16'h0000; req_last = 2'b00;
    repeat (3) tick();
    chk("reset_ser_tx", 32'(ser_tx), 32'd1);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_grant", 32'(grant_id), 32'd0);
    resetn = 1'b1;
    tick();

    // Single byte 0x55 from req0
    req_valid = 2'b01; req_data = 16'h0055; req_last = 2'b01;
    exp_q.push_back(8'h55);
    #1 chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    #1;
    chk("single_ready_pulse", 32'(req_ready), 32'h0);
    chk("single_start_low", 32'(ser_tx), 32'd0);
    chk("single_busy", 32'(busy), 32'd1);
    wait_idle(200, n);
    chk("single_busy_len", 32'(n), 32'd80);

    // Data hold: bus changes after acceptance must not reach the line
    req_valid = 2'b01; req_data = 16'h0000; req_last = 2'b01;
    exp_q.push_back(8'h00);
    #1 chk("hold_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    tick();
    req_data = 16'h00FF;
    wait_idle(200, n);
    chk("hold_busy_len", 32'(n), 32'd79);

    // Packet lock: req0 "AB" while req1 waits with 0x5A
    start_q.delete();
    req_valid = 2'b01; req_data = 16'h0041; req_last = 2'b00;
    exp_q.push_back(8'h41);
    #1 chk("lock_first_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b11; req_data = 16'h5A42; req_last = 2'b11;
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h5A);
    #1 chk("lock_hold_off", 32'(req_ready), 32'h0);
    wait_ready(200, n);
    chk("lock_next_at_stop", 32'(n), 32'd79);
    chk("lock_owner_only", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b10;
    #1 chk("lock_second_pulse", 32'(req_ready), 32'h0);
    wait_ready(200, n);
    chk("lock_other_wait", 32'(n), 32'd80);
    chk("lock_other_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    #1 chk("lock_grant_id", 32'(grant_id), 32'd1);
    wait_idle(200, n);
    gap = (start_q.size() >= 2) ? (start_q[1] - start_q[0]) : -1;
    chk("lock_b2b_gap", 32'(gap), 32'd80);

    // Lock timeout: req0 leaves a packet open, req1 pending
    req_valid = 2'b01; req_data = 16'h6633; req_last = 2'b10;
    exp_q.push_back(8'h33);
    #1 chk("to_first_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b10;
    wait_ready(300, n);
    chk("to_grant_at", 32'(n), 32'd96);
    chk("to_grant_req1", 32'(req_ready), 32'h2);
    exp_q.push_back(8'h66);
    tick();
    req_valid = 2'b00;
    wait_idle(200, n);
    chk("to_drain", 32'(n < 200), 32'd1);

    // Reset abort in bit 3 of a frame from req1
    req_valid = 2'b10; req_data = 16'hA500; req_last = 2'b10;
    #1 chk("abort_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    repeat (36) tick();
    chk("abort_mid_bit3", 32'(ser_tx), 32'd0);
    chk("abort_mid_grant", 32'(grant_id), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("abort_tx_high", 32'(ser_tx), 32'd1);
    chk("abort_ready_low", 32'(req_ready), 32'h0);
    chk("abort_busy_low", 32'(busy), 32'd0);
    chk("abort_grant_zero", 32'(grant_id), 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    n = 0;
    repeat (100) begin
      tick();
      if (ser_tx !== 1'b1 || busy !== 1'b0) n++;
    end
    chk("abort_line_idle", 32'(n), 32'd0);

    // Arbitration with both requesters continuously valid
    req_valid = 2'b11; req_data = 16'h2010; req_last = 2'b11;
    prev = 0;
    for (int g = 0; g < 4; g++) begin
      wait_ready(200, n);
      chk("arb_wait", 32'(n < 200), 32'd1);
`ifdef UART_ARB_FIXED_PRIO_EN
      e = 0;
`else
      e = (prev + 1) % 2;
`endif
      oh = (e == 0) ? 2'b01 : 2'b10;
      chk("arb_ready", 32'(req_ready), 32'(oh));
      exp_q.push_back((e == 0) ? 8'h10 : 8'h20);
      tick();
      chk("arb_grant_id", 32'(grant_id), 32'(e));
      prev = e;
    end
    req_valid = 2'b00;
    wait_idle(200, n);
    repeat (20) tick();
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
